// File: rtl/calc_seq.sv
// Keypad-to-ALU sequencer: builds BCD operands from key entry, drives the
// combinational ALU, waits a fixed settle time and captures the result.
module calc_seq #(
  parameter int DIGIT_NUM = 8,
  parameter int ALU_WAIT  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     key_valid,
  input  logic [4:0]               key_code,
  output logic                     key_ready,
  output logic                     op0_sign,
  output logic [DIGIT_NUM*4-1:0]   op0,
  output logic [2:0]               op0_dp,
  output logic                     op1_sign,
  output logic [DIGIT_NUM*4-1:0]   op1,
  output logic [2:0]               op1_dp,
  output logic [2:0]               operation,
  input  logic [DIGIT_NUM*4-1:0]   alu_result,
  input  logic                     alu_result_sign,
  input  logic [2:0]               alu_result_dp,
  output logic [DIGIT_NUM*4-1:0]   disp,
  output logic                     disp_sign,
  output logic [2:0]               disp_dp,
  output logic                     result_valid,
  output logic                     err
);

  localparam int OPW = DIGIT_NUM * 4;
  localparam int CW  = $clog2(DIGIT_NUM + 1);
  localparam int WW  = (ALU_WAIT > 1) ? $clog2(ALU_WAIT) : 1;
  localparam logic [CW-1:0] CNT_MAX   = CW'(DIGIT_NUM);
  localparam logic [WW-1:0] WAIT_LAST = WW'(ALU_WAIT - 1);

  localparam logic [4:0] K_DOT = 5'd10;
  localparam logic [4:0] K_ADD = 5'd11;
  localparam logic [4:0] K_DIV = 5'd14;
  localparam logic [4:0] K_EQ  = 5'd15;
  localparam logic [4:0] K_CLR = 5'd16;
  localparam logic [4:0] K_SGN = 5'd17;

  typedef enum logic [2:0] {ENTRY0, ENTRY1, EXEC, SHOW, ERR} state_t;

  state_t          state, state_nxt;
  logic [OPW-1:0]  op0_nxt, op1_nxt;
  logic            op0_sign_nxt, op1_sign_nxt;
  logic [2:0]      op0_dp_nxt, op1_dp_nxt, operation_nxt;
  logic [2:0]      pending_op, pending_op_nxt;
  logic            chain, chain_nxt;
  logic            dot_seen, dot_seen_nxt;
  logic            entered, entered_nxt;
  logic            err_nxt, rv_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [WW-1:0]   wait_cnt, wait_nxt;

  logic            key_acc, clr, is_digit, is_op, dig_ok;
  logic [3:0]      digit;
  logic [2:0]      op_code, ed_dp, dig_dp;
  logic [OPW-1:0]  ed_val;

  function automatic logic [2:0] sat_dp(input logic [2:0] dp);
    return (dp == 3'd7) ? 3'd7 : dp + 3'd1;
  endfunction

  function automatic logic [OPW-1:0] shift_in(input logic [OPW-1:0] v,
                                              input logic [3:0] d);
    return {v[OPW-5:0], d};
  endfunction

  assign key_ready = (state != EXEC);
  assign key_acc   = key_valid && key_ready;
  assign clr       = key_valid && (key_code == K_CLR);
  assign is_digit  = (key_code < K_DOT);
  assign is_op     = (key_code >= K_ADD) && (key_code <= K_DIV);
  assign digit     = key_code[3:0];
  assign op_code   = key_code[2:0] - 3'd3;
  assign ed_val    = (state == ENTRY1) ? op1 : op0;
  assign ed_dp     = (state == ENTRY1) ? op1_dp : op0_dp;
  assign dig_dp    = dot_seen ? sat_dp(ed_dp) : ed_dp;
  // Leading zeros before the dot carry no information and are not counted.
  assign dig_ok    = ((digit != 4'd0) || (cnt != '0) || dot_seen) &&
                     (cnt != CNT_MAX) && !(dot_seen && (ed_dp == 3'd7));

  always_comb begin
    state_nxt      = state;
    op0_nxt        = op0;
    op0_sign_nxt   = op0_sign;
    op0_dp_nxt     = op0_dp;
    op1_nxt        = op1;
    op1_sign_nxt   = op1_sign;
    op1_dp_nxt     = op1_dp;
    operation_nxt  = operation;
    pending_op_nxt = pending_op;
    chain_nxt      = chain;
    dot_seen_nxt   = dot_seen;
    entered_nxt    = entered;
    cnt_nxt        = cnt;
    wait_nxt       = wait_cnt;
    err_nxt        = err;
    rv_nxt         = 1'b0;

    unique case (state)
      ENTRY0, ENTRY1: begin
        if (key_acc) begin
          if (is_digit) begin
            if (state == ENTRY1) entered_nxt = 1'b1;
            if (dig_ok) begin
              cnt_nxt = cnt + CW'(1);
              if (state == ENTRY1) begin
                op1_nxt    = shift_in(ed_val, digit);
                op1_dp_nxt = dig_dp;
              end else begin
                op0_nxt    = shift_in(ed_val, digit);
                op0_dp_nxt = dig_dp;
              end
            end
          end else if (key_code == K_DOT) begin
            dot_seen_nxt = 1'b1;
            if (state == ENTRY1) entered_nxt = 1'b1;
          end else if (key_code == K_SGN) begin
            if (state == ENTRY1) op1_sign_nxt = !op1_sign;
            else                 op0_sign_nxt = !op0_sign;
          end else if (is_op) begin
            if (state == ENTRY0) begin
              operation_nxt = op_code;
              op1_nxt       = '0;
              op1_sign_nxt  = 1'b0;
              op1_dp_nxt    = 3'd0;
              dot_seen_nxt  = 1'b0;
              entered_nxt   = 1'b0;
              cnt_nxt       = '0;
              state_nxt     = ENTRY1;
            end else if (!entered) begin
              operation_nxt = op_code;
            end else begin
              pending_op_nxt = op_code;
              chain_nxt      = 1'b1;
              wait_nxt       = '0;
              state_nxt      = EXEC;
            end
          end else if ((key_code == K_EQ) && (state == ENTRY1)) begin
            chain_nxt = 1'b0;
            wait_nxt  = '0;
            state_nxt = EXEC;
          end
        end
      end

      EXEC: begin
        wait_nxt = wait_cnt + WW'(1);
        if (wait_cnt == WAIT_LAST) begin
          if ((operation == 3'd3) && (op1 == '0)) begin
            err_nxt   = 1'b1;
            state_nxt = ERR;
          end else begin
            op0_nxt      = alu_result;
            op0_sign_nxt = alu_result_sign;
            op0_dp_nxt   = alu_result_dp;
            rv_nxt       = 1'b1;
            if (chain) begin
              operation_nxt = pending_op;
              op1_nxt       = '0;
              op1_sign_nxt  = 1'b0;
              op1_dp_nxt    = 3'd0;
              dot_seen_nxt  = 1'b0;
              entered_nxt   = 1'b0;
              cnt_nxt       = '0;
              chain_nxt     = 1'b0;
              state_nxt     = ENTRY1;
            end else begin
              state_nxt = SHOW;
            end
          end
        end
      end

      SHOW: begin
        if (key_acc) begin
          if (is_digit || (key_code == K_DOT)) begin
            // Fresh entry: the previous result is discarded.
            op0_nxt      = '0;
            op0_sign_nxt = 1'b0;
            op0_dp_nxt   = 3'd0;
            op1_nxt      = '0;
            op1_sign_nxt = 1'b0;
            op1_dp_nxt   = 3'd0;
            entered_nxt  = 1'b0;
            chain_nxt    = 1'b0;
            dot_seen_nxt = (key_code == K_DOT);
            cnt_nxt      = '0;
            if (is_digit) begin
              op0_nxt = OPW'(digit);
              cnt_nxt = (digit != 4'd0) ? CW'(1) : '0;
            end
            state_nxt = ENTRY0;
          end else if (key_code == K_SGN) begin
            op0_sign_nxt = !op0_sign;
          end else if (is_op) begin
            operation_nxt = op_code;
            op1_nxt       = '0;
            op1_sign_nxt  = 1'b0;
            op1_dp_nxt    = 3'd0;
            dot_seen_nxt  = 1'b0;
            entered_nxt   = 1'b0;
            cnt_nxt       = '0;
            state_nxt     = ENTRY1;
          end
        end
      end

      default: ;
    endcase
  end

  // Clear behaves like reset and beats a capture due at the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      state        <= ENTRY0;
      op0          <= '0;
      op0_sign     <= 1'b0;
      op0_dp       <= 3'd0;
      op1          <= '0;
      op1_sign     <= 1'b0;
      op1_dp       <= 3'd0;
      operation    <= 3'd0;
      pending_op   <= 3'd0;
      chain        <= 1'b0;
      dot_seen     <= 1'b0;
      entered      <= 1'b0;
      cnt          <= '0;
      wait_cnt     <= '0;
      err          <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      state        <= state_nxt;
      op0          <= op0_nxt;
      op0_sign     <= op0_sign_nxt;
      op0_dp       <= op0_dp_nxt;
      op1          <= op1_nxt;
      op1_sign     <= op1_sign_nxt;
      op1_dp       <= op1_dp_nxt;
      operation    <= operation_nxt;
      pending_op   <= pending_op_nxt;
      chain        <= chain_nxt;
      dot_seen     <= dot_seen_nxt;
      entered      <= entered_nxt;
      cnt          <= cnt_nxt;
      wait_cnt     <= wait_nxt;
      err          <= err_nxt;
      result_valid <= rv_nxt;
    end
  end

  always_comb begin
    disp      = op0;
    disp_sign = op0_sign;
    disp_dp   = op0_dp;
    if (state == ERR) begin
      disp      = '0;
      disp_sign = 1'b0;
      disp_dp   = 3'd0;
    end else if (((state == ENTRY1) || (state == EXEC)) && entered) begin
      disp      = op1;
      disp_sign = op1_sign;
      disp_dp   = op1_dp;
    end
  end

endmodule

// File: tb/tb_calc_seq.sv
// Directed bench for calc_seq with a behavioural BCD ALU attached.
module tb_calc_seq;
  localparam int DIGIT_NUM = 8;
  localparam int ALU_WAIT  = 4;
  localparam int OPW = DIGIT_NUM * 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           key_valid;
  logic [4:0]     key_code;
  logic           key_ready;
  logic           op0_sign, op1_sign, disp_sign, alu_result_sign;
  logic [OPW-1:0] op0, op1, disp, alu_result;
  logic [2:0]     op0_dp, op1_dp, disp_dp, alu_result_dp, operation;
  logic           result_valid, err;

  int n_chk = 0;
  int n_pass = 0;
  int busy, rv_n, rv_c;

  calc_seq #(.DIGIT_NUM(DIGIT_NUM), .ALU_WAIT(ALU_WAIT)) dut (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_code(key_code),
    .key_ready(key_ready),
    .op0_sign(op0_sign), .op0(op0), .op0_dp(op0_dp),
    .op1_sign(op1_sign), .op1(op1), .op1_dp(op1_dp),
    .operation(operation),
    .alu_result(alu_result), .alu_result_sign(alu_result_sign),
    .alu_result_dp(alu_result_dp),
    .disp(disp), .disp_sign(disp_sign), .disp_dp(disp_dp),
    .result_valid(result_valid), .err(err)
  );

  always #5 clk = ~clk;

  function automatic longint bcd2int(input logic [OPW-1:0] v);
    longint r = 0;
    for (int i = DIGIT_NUM - 1; i >= 0; i--) r = r * 10 + longint'(v[i*4 +: 4]);
    return r;
  endfunction

  function automatic logic [OPW-1:0] int2bcd(input longint v);
    logic [OPW-1:0] r = '0;
    longint t = v;
    for (int i = 0; i < DIGIT_NUM; i++) begin
      r[i*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Integer-only ALU model; decimal point is not modelled.
  always_comb begin
    longint a, b, r;
    a = bcd2int(op0);
    if (op0_sign) a = -a;
    b = bcd2int(op1);
    if (op1_sign) b = -b;
    case (operation)
      3'd0:    r = a + b;
      3'd1:    r = a - b;
      3'd2:    r = a * b;
      default: r = (b != 0) ? a / b : 0;
    endcase
    alu_result_sign = (r < 0);
    alu_result      = int2bcd((r < 0) ? -r : r);
    alu_result_dp   = 3'd0;
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic press(input logic [4:0] code);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = code;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  // Starts at the negedge right after the edge that entered EXEC.
  task automatic run_exec(output int busy_o, output int rvn_o, output int rvc_o);
    busy_o = 0; rvn_o = 0; rvc_o = 0;
    for (int c = 1; c <= ALU_WAIT + 3; c++) begin
      if (!key_ready) busy_o++;
      if (result_valid) begin
        rvn_o++;
        if (rvc_o == 0) rvc_o = c;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    rst_n = 1'b0; key_valid = 1'b0; key_code = 5'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_op0", op0, 0);
    chk("rst_op1", op1, 0);
    chk("rst_ready", key_ready, 1);
    chk("rst_err_rv", {err, result_valid, operation}, 0);
    chk("rst_disp", {disp_sign, disp, disp_dp}, 0);

    // 12 + 3
    press(5'd1); press(5'd2); press(5'd11); press(5'd3);
    chk("add_op1_disp", disp, 'h3);
    press(5'd15);
    chk("exec_op0", op0, 'h12);
    chk("exec_op1", op1, 'h3);
    chk("exec_oper", operation, 0);
    run_exec(busy, rv_n, rv_c);
    chk("exec_busy", busy, ALU_WAIT);
    chk("exec_rv_once", rv_n, 1);
    chk("exec_rv_cycle", rv_c, ALU_WAIT + 1);
    chk("add_disp", disp, 'h15);
    chk("show_ready", key_ready, 1);

    // digit limit, leading zeros, dot
    press(5'd16);
    repeat (10) press(5'd9);
    chk("nine_limit", op0, 'h99999999);
    press(5'd16);
    press(5'd0); press(5'd0); press(5'd10); press(5'd5);
    chk("lead0_op0", op0, 'h5);
    chk("lead0_dp", op0_dp, 1);
    press(5'd16);
    press(5'd10);
    for (int d = 1; d <= 8; d++) press(5'(d));
    chk("dp_sat_op0", op0, 'h1234567);
    chk("dp_sat_dp", op0_dp, 7);

    // divide by zero
    press(5'd16);
    press(5'd8); press(5'd14); press(5'd0); press(5'd15);
    run_exec(busy, rv_n, rv_c);
    chk("div0_err", err, 1);
    chk("div0_disp", disp, 0);
    chk("div0_no_rv", rv_n, 0);
    press(5'd3);
    chk("err_ignore", {op0, op1}, {32'h8, 32'h0});
    press(5'd16);
    chk("clr_all", {err, op0, op1, operation, op0_dp, op0_sign}, 0);
    chk("clr_ready", key_ready, 1);

    // chain 2*3+4
    press(5'd2); press(5'd13); press(5'd3); press(5'd11);
    run_exec(busy, rv_n, rv_c);
    chk("chain_op0", op0, 'h6);
    chk("chain_oper", operation, 0);
    chk("chain_rv", rv_n, 1);
    press(5'd4);
    chk("chain_op1", op1, 'h4);
    press(5'd15);
    run_exec(busy, rv_n, rv_c);
    chk("chain_disp", disp, 'h10);

    // sign toggle: -5 + 3
    press(5'd16);
    press(5'd5); press(5'd17);
    chk("sign_op0", op0_sign, 1);
    press(5'd11); press(5'd3); press(5'd15);
    run_exec(busy, rv_n, rv_c);
    chk("sign_res", {disp_sign, disp}, {1'b1, 32'h2});

    // key held during EXEC
    press(5'd16);
    press(5'd1); press(5'd11); press(5'd2);
    @(negedge clk);
    key_valid = 1'b1; key_code = 5'd15;
    @(negedge clk);
    key_code = 5'd7;
    repeat (ALU_WAIT - 1) @(negedge clk);
    chk("hold_exec_ops", {op0, op1}, {32'h1, 32'h2});
    @(negedge clk);
    chk("hold_capture", {result_valid, op0}, {1'b1, 32'h3});
    @(negedge clk);
    key_valid = 1'b0;
    chk("hold_once", op0, 'h7);

    // clear during the capture edge
    press(5'd16);
    press(5'd1); press(5'd11); press(5'd2); press(5'd15);
    repeat (ALU_WAIT - 1) @(negedge clk);
    key_valid = 1'b1; key_code = 5'd16;
    @(negedge clk);
    key_valid = 1'b0;
    chk("clr_exec", {result_valid, op0, op1, key_ready}, {1'b0, 32'h0, 32'h0, 1'b1});

    // reset mid-EXEC
    press(5'd1); press(5'd11); press(5'd2); press(5'd15);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_exec", {op0, op1, operation, key_ready}, {32'h0, 32'h0, 3'd0, 1'b1});
    run_exec(busy, rv_n, rv_c);
    chk("rst_exec_no_rv", rv_n, 0);

    // reset mid-entry
    press(5'd4); press(5'd5);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_entry", {op0, disp, key_ready}, {32'h0, 32'h0, 1'b1});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/calc_seq.md
# calc_seq

Keypad-to-ALU sequencer for the calculator datapath. It accepts one key code per handshake and builds BCD operands (sign, digits, decimal-point position) from digit entry. It drives the combinational ALU's operand/operation inputs, waits a fixed settle time, captures the result, and supports operator chaining. It sits between the keypad decoder and the ALU/display path.

## Interface
- DIGIT_NUM, 8: operand length in BCD digits; operand registers are DIGIT_NUM*4 bits.
- ALU_WAIT, 4: cycles the ALU inputs are held stable before the result is captured (≥1).
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  reset: one clock, synchronous, active-low.
- key_valid  in  1  key code present.
- key_code  in  5  0–9 digit; 10 dot; 11 add; 12 sub; 13 mul; 14 div; 15 equals; 16 clear; 17 sign toggle; 18–31 ignored.
- key_ready  out  1  sequencer can accept a key.
- op0_sign, op0, op0_dp  out  1, DIGIT_NUM*4, 3  operand0 to the ALU.
- op1_sign, op1, op1_dp  out  1, DIGIT_NUM*4, 3  operand1 to the ALU.
- operation  out  3  ALU operation: 0 add, 1 sub, 2 mul, 3 div.
- alu_result, alu_result_sign, alu_result_dp  in  DIGIT_NUM*4, 1, 3  ALU outputs.
- disp, disp_sign, disp_dp  out  DIGIT_NUM*4, 1, 3  value to display.
- result_valid  out  1  one-cycle pulse when a result is captured.
- err  out  1  divide-by-zero flag; held until clear.

## Operation
- States: ENTRY0, ENTRY1, EXEC, SHOW, ERR. Reset state is ENTRY0.
- Reset values: all operand, disp and dp outputs 0; signs 0; operation 0; result_valid 0; err 0; key_ready 1.
- A key is accepted when key_valid && key_ready. Keys presented while key_ready=0 are dropped, not queued.
- Digit entry into the edited operand (op0 in ENTRY0, op1 in ENTRY1):
  - operand = {operand[DIGIT_NUM*4-5:0], digit}; the digit count increments.
  - The digit is ignored once the count reaches DIGIT_NUM.
  - A leading 0 before any dot is not counted.
- Dot sets the dot_seen flag. A second dot is ignored.
- Each counted digit after the dot increments dp, saturating at 7. At dp=7 the digit itself is also ignored.
- Sign toggle inverts the sign of the edited operand; in SHOW it inverts op0_sign.
- ENTRY0:
  - Operator: latch operation; clear op1, op1_sign, op1_dp and the entry flags; go to ENTRY1.
  - Equals: ignored.
- ENTRY1:
  - Operator with no op1 digit entered: replaces operation.
  - Operator after ≥1 digit: latch it as pending_op, then go to EXEC (chain).
  - Equals: go to EXEC, even if op1 is empty (op1 = 0).
- EXEC:
  - key_ready=0; counter runs 0..ALU_WAIT-1.
  - On the last count: if operation=3 and op1=0, go to ERR (err=1, disp=0).
  - Otherwise op0/op0_sign/op0_dp ← alu_result/alu_result_sign/alu_result_dp, and result_valid pulses.
  - If chaining: operation ← pending_op, op1 cleared, go to ENTRY1. Otherwise go to SHOW.
- SHOW:
  - Operator: latch it, clear op1, go to ENTRY1 (the result is reused as operand0).
  - Digit: clear all operands and flags, load the digit into op0, go to ENTRY0.
  - Dot: same as digit, but loads "0." (op0=0, dot_seen=1).
  - Equals: ignored.
- ERR: every key except clear is ignored.
- Clear (any state, including EXEC): returns all registers to reset values; state ENTRY0.
- disp/disp_sign/disp_dp:
  - ENTRY0 and SHOW: op0.
  - ENTRY1: op1 once a digit or dot has been entered, else op0.
  - ERR: 0.
- op0/op1 outputs are registered and stay stable for the whole of EXEC.

## Timing
- An accepted key takes effect at the same edge; outputs are updated in the next cycle.
- Equals accepted at edge 0:
  - key_ready=0 and state EXEC during cycles 1..ALU_WAIT.
  - Capture at edge ALU_WAIT.
  - result_valid=1 and key_ready=1 in cycle ALU_WAIT+1.
- key_ready is combinational from state (0 only in EXEC).
- Clear together with key_valid during EXEC: clear wins; no capture or result_valid occurs.
- rst_n low at any edge overrides everything, including a capture due at that edge.

## Test plan
- Keys 1,2,add,3,equals, ALU model adds → op0=0x12, op1=0x3, operation=0 during EXEC; result_valid pulses once at cycle ALU_WAIT+1 after equals; disp=0x15, state SHOW.
- Keys 9 ×10 → op0=0x99999999; 9th and 10th digits dropped. Keys 0,0,dot,5 → op0=0x5, dp=1, count 1.
- Keys 8,div,0,equals → err=1, disp=0 after ALU_WAIT cycles; digit 3 then ignored; clear → all reset values, err=0.
- Chain 2,mul,3,add,4,equals → first capture op0=6, operation becomes 0, op1=4; second result disp=10 (0x10).
- key_valid held high with digit 7 during EXEC → no change to operands; digit accepted only once key_ready returns.
- rst_n=0 mid-EXEC and mid-entry → next cycle all outputs at reset values, key_ready=1, no result_valid.
